// File: rtl/lfsr_checker.sv
// Serial PRBS checker for the 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1).
// Hunts for sync on the raw stream, then flywheels on its own prediction and counts bit errors.
module lfsr_checker #(
  parameter int LOCK_CNT    = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic        sync_loss,
  output logic [15:0] err_count,
  output logic [31:0] bit_count
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int WC_W = $clog2(WINDOW + 1);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [5:0] FILL_FULL = 6'd32;

  logic [0:0]      state_q,     state_d;
  logic [31:0]     shift_q,     shift_d;
  logic [5:0]      fill_q,      fill_d;
  logic [MC_W-1:0] matchCnt_q,  matchCnt_d;
  logic [WC_W-1:0] winCnt_q,    winCnt_d;
  logic [WE_W-1:0] winErr_q,    winErr_d;
  logic            errPulse_q,  errPulse_d;
  logic            syncLoss_q,  syncLoss_d;
  logic [15:0]     errCount_q,  errCount_d;
  logic [31:0]     bitCount_q,  bitCount_d;

  logic            predBit;
  logic            mismatch;
  logic            historyNonZero;
  logic [MC_W-1:0] matchCntInc;
  logic [WC_W-1:0] winCntInc;
  logic [WE_W-1:0] winErrInc;

  // S[0] is the newest bit, so the taps read the generator's feedback directly.
  assign predBit        = shift_q[31] ^ shift_q[21] ^ shift_q[1] ^ shift_q[0];
  assign mismatch       = in_bit ^ predBit;
  assign historyNonZero = |shift_q;
  assign matchCntInc    = matchCnt_q + 1'b1;
  assign winCntInc      = winCnt_q + 1'b1;
  assign winErrInc      = winErr_q + {{(WE_W-1){1'b0}}, mismatch};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    fill_d     = fill_q;
    matchCnt_d = matchCnt_q;
    winCnt_d   = winCnt_q;
    winErr_d   = winErr_q;
    errPulse_d = 1'b0;
    syncLoss_d = 1'b0;
    errCount_d = errCount_q;
    bitCount_d = bitCount_q;

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          shift_d = {shift_q[30:0], in_bit};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 6'd1;
          end else if (!mismatch && historyNonZero) begin
            if (matchCntInc == MC_W'(LOCK_CNT)) begin
              state_d    = ST_LOCKED;
              matchCnt_d = '0;
              winCnt_d   = '0;
              winErr_d   = '0;
            end else begin
              matchCnt_d = matchCntInc;
            end
          end else begin
            // An all-zero history predicts zeros forever, so it never counts as a match.
            matchCnt_d = '0;
          end
        end

        default: begin
          // Flywheel: the prediction, not the received bit, feeds the history.
          shift_d = {shift_q[30:0], predBit};
          if (bitCount_q != 32'hFFFF_FFFF) begin
            bitCount_d = bitCount_q + 32'd1;
          end
          if (mismatch) begin
            errPulse_d = 1'b1;
            if (errCount_q != 16'hFFFF) begin
              errCount_d = errCount_q + 16'd1;
            end
          end
          if (winErrInc == WE_W'(LOSS_THRESH)) begin
            state_d    = ST_HUNT;
            syncLoss_d = 1'b1;
            fill_d     = '0;
            matchCnt_d = '0;
            winCnt_d   = '0;
            winErr_d   = '0;
          end else if (winCntInc == WC_W'(WINDOW)) begin
            winCnt_d = '0;
            winErr_d = '0;
          end else begin
            winCnt_d = winCntInc;
            winErr_d = winErrInc;
          end
        end
      endcase
    end

    if (clear) begin
      errCount_d = '0;
      bitCount_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      shift_q    <= '0;
      fill_q     <= '0;
      matchCnt_q <= '0;
      winCnt_q   <= '0;
      winErr_q   <= '0;
      errPulse_q <= 1'b0;
      syncLoss_q <= 1'b0;
      errCount_q <= '0;
      bitCount_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      fill_q     <= fill_d;
      matchCnt_q <= matchCnt_d;
      winCnt_q   <= winCnt_d;
      winErr_q   <= winErr_d;
      errPulse_q <= errPulse_d;
      syncLoss_q <= syncLoss_d;
      errCount_q <= errCount_d;
      bitCount_q <= bitCount_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = errPulse_q;
  assign sync_loss = syncLoss_q;
  assign err_count = errCount_q;
  assign bit_count = bitCount_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a software PRBS source with error injection drives the checker,
// and a queue-based behavioural model predicts every output on every cycle.
module tb_lfsr_checker;

  localparam int LOCK_CNT    = 32;
  localparam int WINDOW      = 64;
  localparam int LOSS_THRESH = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic        sync_loss;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  int nCompared   = 0;
  int nMismatched = 0;
  int pulseSeen   = 0;
  int lockSeen    = 0;

  bit [31:0] tbLfsr;

  bit     hist[$];
  bit     mLocked;
  int     mFill, mMatch, mWin, mWerr, mErr;
  longint mBits;
  bit     ePulse, eLoss;

  lfsr_checker #(
    .LOCK_CNT   (LOCK_CNT),
    .WINDOW     (WINDOW),
    .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .clear    (clear),
    .locked   (locked),
    .err_pulse(err_pulse),
    .sync_loss(sync_loss),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < 32; i++) hist.push_back(1'b0);
    mLocked = 1'b0;
    mFill = 0; mMatch = 0; mWin = 0; mWerr = 0; mErr = 0;
    mBits = 0;
    ePulse = 1'b0; eLoss = 1'b0;
  endtask

  // hist[31] is the newest received/predicted bit, hist[0] the one 32 beats back.
  task automatic modelStep(input bit v, input bit b, input bit clr);
    bit p;
    bit anyOne;
    ePulse = 1'b0;
    eLoss  = 1'b0;
    if (v) begin
      p = hist[0] ^ hist[10] ^ hist[30] ^ hist[31];
      if (!mLocked) begin
        anyOne = 1'b0;
        foreach (hist[i]) if (hist[i]) anyOne = 1'b1;
        hist.push_back(b);
        void'(hist.pop_front());
        if (mFill < 32) mFill++;
        else if (b == p && anyOne) begin
          mMatch++;
          if (mMatch == LOCK_CNT) begin
            mLocked = 1'b1; mMatch = 0; mWin = 0; mWerr = 0;
          end
        end else mMatch = 0;
      end else begin
        hist.push_back(p);
        void'(hist.pop_front());
        if (mBits < 64'hFFFF_FFFF) mBits++;
        mWin++;
        if (b != p) begin
          ePulse = 1'b1;
          if (mErr < 65535) mErr++;
          mWerr++;
        end
        if (mWerr == LOSS_THRESH) begin
          eLoss = 1'b1; mLocked = 1'b0;
          mFill = 0; mMatch = 0; mWin = 0; mWerr = 0;
        end else if (mWin == WINDOW) begin
          mWin = 0; mWerr = 0;
        end
      end
    end
    if (clr) begin
      mErr = 0; mBits = 0;
    end
  endtask

  task automatic applyStimulus(input bit v, input bit b, input bit clr);
    in_valid = v;
    in_bit   = b;
    clear    = clr;
    @(posedge clk);
    modelStep(v, b, clr);
    #1;
    checkOutput("locked",    {31'd0, locked},    {31'd0, mLocked});
    checkOutput("err_pulse", {31'd0, err_pulse}, {31'd0, ePulse});
    checkOutput("sync_loss", {31'd0, sync_loss}, {31'd0, eLoss});
    checkOutput("err_count", {16'd0, err_count}, mErr[31:0]);
    checkOutput("bit_count", bit_count,          mBits[31:0]);
    if (err_pulse) pulseSeen++;
    if (locked) lockSeen++;
  endtask

  task automatic genBit(output bit b);
    bit fb;
    fb = tbLfsr[31] ^ tbLfsr[21] ^ tbLfsr[1] ^ tbLfsr[0];
    tbLfsr = {tbLfsr[30:0], fb};
    b = fb;
  endtask

  task automatic cleanBeats(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      genBit(b);
      applyStimulus(1'b1, b, 1'b0);
    end
  endtask

  task automatic errorBeat(input bit clr);
    bit b;
    genBit(b);
    applyStimulus(1'b1, ~b, clr);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_locked"},    {31'd0, locked},    32'd0);
    checkOutput({tag, "_err_pulse"}, {31'd0, err_pulse}, 32'd0);
    checkOutput({tag, "_sync_loss"}, {31'd0, sync_loss}, 32'd0);
    checkOutput({tag, "_err_count"}, {16'd0, err_count}, 32'd0);
    checkOutput({tag, "_bit_count"}, bit_count,          32'd0);
  endtask

  initial begin
    bit b;
    int nValid;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
    tbLfsr   = 32'hACE1ACE1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] clean lock from seed ACE1ACE1");
    cleanBeats(63);
    checkOutput("notLockedAt63", {31'd0, locked}, 32'd0);
    cleanBeats(1);
    checkOutput("lockedAt64", {31'd0, locked}, 32'd1);
    pulseSeen = 0;
    cleanBeats(1000);
    checkOutput("bitCount1000", bit_count, 32'd1000);
    checkOutput("errCountClean", {16'd0, err_count}, 32'd0);
    checkOutput("noPulseClean", pulseSeen, 32'd0);

    $display("[TB] single error while locked");
    errorBeat(1'b0);
    checkOutput("singleErrPulse", {31'd0, err_pulse}, 32'd1);
    pulseSeen = 0;
    cleanBeats(100);
    checkOutput("singleErrCount", {16'd0, err_count}, 32'd1);
    checkOutput("flywheelNoPulse", pulseSeen, 32'd0);
    checkOutput("singleErrLocked", {31'd0, locked}, 32'd1);

    $display("[TB] eight errors inside one window");
    for (int k = 0; k <= 28; k++) begin
      if (k % 4 == 0) errorBeat(1'b0);
      else cleanBeats(1);
    end
    checkOutput("lossPulse", {31'd0, sync_loss}, 32'd1);
    checkOutput("lossUnlocked", {31'd0, locked}, 32'd0);
    cleanBeats(63);
    checkOutput("relockNotAt63", {31'd0, locked}, 32'd0);
    cleanBeats(1);
    checkOutput("relockAt64", {31'd0, locked}, 32'd1);

    $display("[TB] seven errors per window, repeated");
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 4 * WINDOW; j++) begin
      if ((j % WINDOW) < 35 && (j % WINDOW) % 5 == 0) errorBeat(1'b0);
      else cleanBeats(1);
    end
    checkOutput("sevenPerWindowLocked", {31'd0, locked}, 32'd1);
    checkOutput("sevenPerWindowCount", {16'd0, err_count}, 32'd28);

    $display("[TB] asynchronous reset while locked");
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncReset");
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] zero stream");
    lockSeen = 0;
    for (int i = 0; i < 2000; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("zeroNeverLocks", lockSeen, 32'd0);
    cleanBeats(64);
    checkOutput("lockAfterZero", {31'd0, locked}, 32'd1);

    $display("[TB] random gaps after reset");
    rst_n = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    nValid = 0;
    for (int c = 0; c < 2000 && nValid < 64; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        genBit(b);
        applyStimulus(1'b1, b, 1'b0);
        nValid++;
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      end
    end
    checkOutput("gapValidBeats", nValid, 32'd64);
    checkOutput("gapLocked", {31'd0, locked}, 32'd1);

    $display("[TB] random gaps, errors and clears");
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3, 0) != 0) begin
        genBit(b);
        if ($urandom_range(49, 0) == 0) b = ~b;
        applyStimulus(1'b1, b, ($urandom_range(63, 0) == 0));
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(1, 0)), ($urandom_range(63, 0) == 0));
      end
    end

    $display("[TB] clear on the same beat as an error");
    cleanBeats(64);
    checkOutput("lockedBeforeClear", {31'd0, locked}, 32'd1);
    errorBeat(1'b1);
    checkOutput("clearErrPulse", {31'd0, err_pulse}, 32'd1);
    checkOutput("clearErrCount", {16'd0, err_count}, 32'd0);
    checkOutput("clearBitCount", bit_count, 32'd0);
    cleanBeats(10);
    checkOutput("postClearBits", bit_count, 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
